// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between the datapath (port 0) and the branch/address unit (port 1).
// Define ALU_ARB_STATS_EN to add the stall_cnt arbitration-loss counter output.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_zero,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic                owner_q;
    logic [WIDTH-1:0]    a_q, b_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic                rsp0_valid_q, rsp1_valid_q;
    logic [WIDTH-1:0]    rsp0_result_q, rsp1_result_q;
    logic                rsp0_zero_q, rsp1_zero_q;
    logic                grant_d;
    logic                accept;

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        grant_d = req1_valid;
        if (req0_valid && req1_valid) grant_d = ~last_grant_q;
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant_d;
    assign req1_ready = (state_q == IDLE) && req1_valid &&  grant_d;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            ctrl_q        <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= grant_d ? req1_a    : req0_a;
                        b_q          <= grant_d ? req1_b    : req0_b;
                        ctrl_q       <= grant_d ? req1_ctrl : req0_ctrl;
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner_q) begin
                        rsp1_valid_q  <= 1'b1;
                        rsp1_result_q <= alu_result;
                        rsp1_zero_q   <= alu_zero;
                    end else begin
                        rsp0_valid_q  <= 1'b1;
                        rsp0_result_q <= alu_result;
                        rsp0_zero_q   <= alu_zero;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_ctrl    = ctrl_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    // Counts IDLE cycles in which one requester loses arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (state_q == IDLE && req0_valid && req1_valid && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
